// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM encodings and
// response codes.
package axil_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both have bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axil_master_cmd_if.sv
// AXI4-Lite AW/W/B/AR/R channel bundle with master and slave views.
interface axil_master_cmd_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module axil_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear first, then increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/axil_master_cmd.sv
// AXI4-Lite master command front end: single write/read commands become
// AXI4-Lite transactions through independent write and read FSMs.
module axil_master_cmd
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_cmd_valid,
  output logic                     wr_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    wr_cmd_addr,
  input  logic [DATA_WIDTH-1:0]    wr_cmd_data,
  input  logic [DATA_WIDTH/8-1:0]  wr_cmd_strb,
  input  logic [2:0]               wr_cmd_prot,
  output logic                     wr_done,
  output logic [1:0]               wr_done_resp,
  input  logic                     rd_cmd_valid,
  output logic                     rd_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]    rd_cmd_addr,
  input  logic [2:0]               rd_cmd_prot,
  output logic                     rd_done,
  output logic [DATA_WIDTH-1:0]    rd_done_data,
  output logic [1:0]               rd_done_resp,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] wr_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] rd_err_cnt,
  axil_master_cmd_if.master        m_axil
);
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_e             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [2:0]            awprot_q, awprot_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  wr_done_q, wr_done_d;
  logic [1:0]            wr_resp_q, wr_resp_d;
  logic                  wr_err_inc_s;

  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rd_done_q, rd_done_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [1:0]            rd_resp_q, rd_resp_d;
  logic                  rd_err_inc_s;

  // Write FSM next state; AW and W valids retire independently.
  always_comb begin
    wr_state_d   = wr_state_q;
    awaddr_d     = awaddr_q;
    awprot_d     = awprot_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    wr_done_d    = 1'b0;
    wr_resp_d    = wr_resp_q;
    wr_err_inc_s = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_cmd_valid) begin
          awaddr_d   = wr_cmd_addr;
          awprot_d   = wr_cmd_prot;
          wdata_d    = wr_cmd_data;
          wstrb_d    = wr_cmd_strb;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_state_d = W_REQ;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_REQ: begin
        if (awvalid_q && m_axil.awready) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && m_axil.wready) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d   = 1'b1;
          wr_state_d = W_RESP;
        end else begin
          wr_state_d = W_REQ;
        end
      end
      W_RESP: begin
        if (m_axil.bvalid && bready_q) begin
          bready_d     = 1'b0;
          wr_done_d    = 1'b1;
          wr_resp_d    = m_axil.bresp;
          wr_err_inc_s = resp_is_err(m_axil.bresp);
          wr_state_d   = W_IDLE;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: begin
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
        bready_d   = 1'b0;
        wr_state_d = W_IDLE;
      end
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q <= W_IDLE;
      awaddr_q   <= {ADDR_WIDTH{1'b0}};
      awprot_q   <= 3'b000;
      wdata_q    <= {DATA_WIDTH{1'b0}};
      wstrb_q    <= {STRB_W{1'b0}};
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_resp_q  <= 2'b00;
    end else begin
      wr_state_q <= wr_state_d;
      awaddr_q   <= awaddr_d;
      awprot_q   <= awprot_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      wr_done_q  <= wr_done_d;
      wr_resp_q  <= wr_resp_d;
    end
  end

  // Read FSM next state.
  always_comb begin
    rd_state_d   = rd_state_q;
    araddr_d     = araddr_q;
    arprot_d     = arprot_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rd_done_d    = 1'b0;
    rd_data_d    = rd_data_q;
    rd_resp_d    = rd_resp_q;
    rd_err_inc_s = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_cmd_valid) begin
          araddr_d   = rd_cmd_addr;
          arprot_d   = rd_cmd_prot;
          arvalid_d  = 1'b1;
          rd_state_d = R_ADDR;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_ADDR: begin
        if (arvalid_q && m_axil.arready) begin
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          rd_state_d = R_DATA;
        end else begin
          rd_state_d = R_ADDR;
        end
      end
      R_DATA: begin
        if (m_axil.rvalid && rready_q) begin
          rready_d     = 1'b0;
          rd_done_d    = 1'b1;
          rd_data_d    = m_axil.rdata;
          rd_resp_d    = m_axil.rresp;
          rd_err_inc_s = resp_is_err(m_axil.rresp);
          rd_state_d   = R_IDLE;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: begin
        arvalid_d  = 1'b0;
        rready_d   = 1'b0;
        rd_state_d = R_IDLE;
      end
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= R_IDLE;
      araddr_q   <= {ADDR_WIDTH{1'b0}};
      arprot_q   <= 3'b000;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      rd_resp_q  <= 2'b00;
    end else begin
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      arprot_q   <= arprot_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      rd_done_q  <= rd_done_d;
      rd_data_q  <= rd_data_d;
      rd_resp_q  <= rd_resp_d;
    end
  end

  axil_sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_wr_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (err_clr),
    .inc_i   (wr_err_inc_s),
    .cnt_o   (wr_err_cnt)
  );

  axil_sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_rd_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (err_clr),
    .inc_i   (rd_err_inc_s),
    .cnt_o   (rd_err_cnt)
  );

  assign wr_cmd_ready   = (wr_state_q == W_IDLE);
  assign rd_cmd_ready   = (rd_state_q == R_IDLE);
  assign wr_done        = wr_done_q;
  assign wr_done_resp   = wr_resp_q;
  assign rd_done        = rd_done_q;
  assign rd_done_data   = rd_data_q;
  assign rd_done_resp   = rd_resp_q;
  assign m_axil.awaddr  = awaddr_q;
  assign m_axil.awprot  = awprot_q;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = araddr_q;
  assign m_axil.arprot  = arprot_q;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;
endmodule

// File: tb/tb_axil_master_cmd.sv
// Scoreboard bench for axil_master_cmd: a configurable AXI4-Lite slave model,
// directed command vectors and a monitor that checks every completion.
module tb_axil_master_cmd;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_cmd_valid, wr_cmd_ready, wr_done;
  logic [31:0] wr_cmd_addr, wr_cmd_data;
  logic [3:0]  wr_cmd_strb;
  logic [2:0]  wr_cmd_prot, rd_cmd_prot;
  logic [1:0]  wr_done_resp, rd_done_resp;
  logic        rd_cmd_valid, rd_cmd_ready, rd_done;
  logic [31:0] rd_cmd_addr, rd_done_data;
  logic        err_clr;
  logic [7:0]  wr_err_cnt, rd_err_cnt;

  axil_master_cmd_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_master_cmd #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_data(wr_cmd_data),
    .wr_cmd_strb(wr_cmd_strb), .wr_cmd_prot(wr_cmd_prot),
    .wr_done(wr_done), .wr_done_resp(wr_done_resp),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_prot(rd_cmd_prot),
    .rd_done(rd_done), .rd_done_data(rd_done_data), .rd_done_resp(rd_done_resp),
    .err_clr(err_clr), .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt),
    .m_axil(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;
  exp_t wr_q[$];
  exp_t rd_q[$];
  exp_t mon_we, mon_re;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Slave model knobs and state
  int          aw_hold = 1, w_hold = 1, ar_hold = 1;
  int          aw_wait, w_wait, ar_wait;
  bit          aw_armed, w_armed, ar_armed, aw_got, w_got, ar_got, b_armed, r_armed;
  logic [1:0]  bresp_val = RESP_OKAY;
  logic [1:0]  rresp_val = RESP_OKAY;
  logic [31:0] rdata_val = 32'h0;

  task automatic slave_reset();
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    aw_armed = 0; w_armed = 0; ar_armed = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_armed = 0; r_armed = 0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
  endtask

  // Slave: a ready raised at a negedge with valid high handshakes at the next posedge.
  initial begin
    slave_reset();
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        slave_reset();
      end else begin
        bus.awready = 1'b0;
        if (aw_armed) begin aw_got = 1; aw_armed = 0; aw_wait = 0; end
        else if (bus.awvalid) begin
          if (aw_wait >= aw_hold - 1) begin bus.awready = 1'b1; aw_armed = 1; end
          else aw_wait++;
        end
        bus.wready = 1'b0;
        if (w_armed) begin w_got = 1; w_armed = 0; w_wait = 0; end
        else if (bus.wvalid) begin
          if (w_wait >= w_hold - 1) begin bus.wready = 1'b1; w_armed = 1; end
          else w_wait++;
        end
        bus.arready = 1'b0;
        if (ar_armed) begin ar_got = 1; ar_armed = 0; ar_wait = 0; end
        else if (bus.arvalid) begin
          if (ar_wait >= ar_hold - 1) begin bus.arready = 1'b1; ar_armed = 1; end
          else ar_wait++;
        end
        if (b_armed) begin bus.bvalid = 1'b0; b_armed = 0; end
        else if (aw_got && w_got && !bus.bvalid) begin
          bus.bvalid = 1'b1; bus.bresp = bresp_val; aw_got = 0; w_got = 0;
        end
        if (bus.bvalid && bus.bready) b_armed = 1;
        if (r_armed) begin bus.rvalid = 1'b0; r_armed = 0; end
        else if (ar_got && !bus.rvalid) begin
          bus.rvalid = 1'b1; bus.rdata = rdata_val; bus.rresp = rresp_val; ar_got = 0;
        end
        if (bus.rvalid && bus.rready) r_armed = 1;
      end
    end
  end

  // Monitor: pops an expectation for every done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && wr_done) begin
        if (wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_done_unexpected: actual=1 required=0 at cycle %0d", cyc);
        end else begin
          mon_we = wr_q.pop_front();
          chk("wr_done_resp", wr_done_resp, mon_we.resp);
          if (mon_we.due >= 0) chk("wr_latency", cyc, mon_we.due);
        end
      end
      if (reset_n && rd_done) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_done_unexpected: actual=1 required=0 at cycle %0d", cyc);
        end else begin
          mon_re = rd_q.pop_front();
          chk("rd_done_data", rd_done_data, mon_re.data);
          chk("rd_done_resp", rd_done_resp, mon_re.resp);
          if (mon_re.due >= 0) chk("rd_latency", cyc, mon_re.due);
        end
      end
    end
  end

  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot,
                             input logic [1:0] resp, input bit timed, output int acc);
    bit ok = 0;
    acc = -1;
    @(negedge clk);
    wr_cmd_valid = 1'b1; wr_cmd_addr = addr; wr_cmd_data = data;
    wr_cmd_strb = strb; wr_cmd_prot = prot;
    for (int i = 0; i < 100; i++) begin
      if (wr_cmd_ready) begin ok = 1; acc = cyc; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wr_accept_timeout: actual=not-ready required=ready");
      wr_cmd_valid = 1'b0;
    end else begin
      wr_q.push_back('{32'h0, resp, timed ? acc + 3 : -1});
      @(posedge clk);
      #1 wr_cmd_valid = 1'b0;
    end
  endtask

  task automatic issue_read(input logic [31:0] addr, input logic [2:0] prot,
                            input logic [31:0] data, input logic [1:0] resp,
                            input bit timed, output int acc);
    bit ok = 0;
    acc = -1;
    @(negedge clk);
    rd_cmd_valid = 1'b1; rd_cmd_addr = addr; rd_cmd_prot = prot;
    for (int i = 0; i < 100; i++) begin
      if (rd_cmd_ready) begin ok = 1; acc = cyc; break; end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL rd_accept_timeout: actual=not-ready required=ready");
      rd_cmd_valid = 1'b0;
    end else begin
      rd_q.push_back('{data, resp, timed ? acc + 3 : -1});
      @(posedge clk);
      #1 rd_cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_q.size() == 0 && rd_q.size() == 0) break;
    end
    chk("queue_drain", wr_q.size() + rd_q.size(), 0);
  endtask

  int acc_a, acc_b, aw_n, w_n, first_b, exp_err;

  initial begin
    wr_cmd_valid = 1'b0; wr_cmd_addr = 32'h0; wr_cmd_data = 32'h0;
    wr_cmd_strb = 4'h0; wr_cmd_prot = 3'b000;
    rd_cmd_valid = 1'b0; rd_cmd_addr = 32'h0; rd_cmd_prot = 3'b000;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_rd_data", rd_done_data, 0);
    chk("rst_wr_err", wr_err_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_wr_ready", wr_cmd_ready, 1);
    chk("idle_rd_ready", rd_cmd_ready, 1);

    // Zero-wait write, then payload as seen on AW/W in the next cycle
    issue_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b010, RESP_OKAY, 1, acc_a);
    @(negedge clk);
    chk("w1_awaddr", bus.awaddr, 32'h10);
    chk("w1_wdata", bus.wdata, 32'hDEADBEEF);
    chk("w1_wstrb", bus.wstrb, 4'hF);
    chk("w1_awprot", bus.awprot, 3'b010);
    chk("w1_awvalid", bus.awvalid, 1);
    chk("w1_wvalid", bus.wvalid, 1);
    chk("w1_busy", wr_cmd_ready, 0);
    wait_idle();

    // Back-to-back writes: second accepted in the done cycle of the first
    bresp_val = RESP_EXOKAY;
    issue_write(32'h14, 32'h1111_2222, 4'h3, 3'b000, RESP_EXOKAY, 1, acc_a);
    issue_write(32'h18, 32'h3333_4444, 4'hC, 3'b001, RESP_EXOKAY, 1, acc_b);
    chk("b2b_accept", acc_b, acc_a + 3);
    wait_idle();
    bresp_val = RESP_OKAY;

    // Zero-wait read, data held after completion
    rdata_val = 32'hCAFEF00D;
    issue_read(32'h30, 3'b100, 32'hCAFEF00D, RESP_OKAY, 1, acc_a);
    @(negedge clk);
    chk("r1_araddr", bus.araddr, 32'h30);
    chk("r1_arprot", bus.arprot, 3'b100);
    chk("r1_arvalid", bus.arvalid, 1);
    chk("r1_rready", bus.rready, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("r1_hold", rd_done_data, 32'hCAFEF00D);

    // AW delayed: awvalid high 4 cycles, W retires after 1, bready after AW
    aw_hold = 4;
    issue_write(32'h40, 32'h0000A5A5, 4'h3, 3'b000, RESP_OKAY, 0, acc_a);
    aw_n = 0; w_n = 0; first_b = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.awvalid) begin
        aw_n++;
        chk("dly_awaddr_stable", bus.awaddr, 32'h40);
      end
      if (bus.wvalid) w_n++;
      if (bus.bready && first_b == 0) first_b = i;
    end
    chk("dly_aw_cycles", aw_n, 4);
    chk("dly_w_cycles", w_n, 1);
    chk("dly_bready_cycle", first_b, 5);
    aw_hold = 1;
    wait_idle();

    // W delayed, AW immediate
    w_hold = 3;
    issue_write(32'h44, 32'h5A5A0000, 4'hC, 3'b000, RESP_OKAY, 0, acc_a);
    wait_idle();
    w_hold = 1;

    // Concurrent write and read
    rdata_val = 32'h12345678;
    fork
      issue_write(32'h20, 32'hAAAA5555, 4'hF, 3'b000, RESP_OKAY, 1, acc_a);
      issue_read(32'h24, 3'b000, 32'h12345678, RESP_OKAY, 1, acc_b);
    join
    chk("conc_accept", acc_a, acc_b);
    chk("conc_awaddr", bus.awaddr, 32'h20);
    chk("conc_araddr", bus.araddr, 32'h24);
    wait_idle();
    chk("conc_rdata_hold", rd_done_data, 32'h12345678);

    // 300 SLVERR writes saturate the write error counter
    bresp_val = RESP_SLVERR;
    exp_err = 0;
    for (int i = 0; i < 300; i++) begin
      issue_write(32'h100 + i * 4, i, 4'hF, 3'b000, RESP_SLVERR, 1, acc_a);
      if (exp_err < 255) exp_err++;
    end
    wait_idle();
    chk("sat_wr_err", wr_err_cnt, exp_err);
    chk("sat_rd_err", rd_err_cnt, 0);
    rresp_val = RESP_DECERR;
    rdata_val = 32'h0BADF00D;
    issue_read(32'h200, 3'b000, 32'h0BADF00D, RESP_DECERR, 1, acc_a);
    wait_idle();
    chk("decerr_rd_err", rd_err_cnt, 1);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("clr_wr_err", wr_err_cnt, 0);
    chk("clr_rd_err", rd_err_cnt, 0);

    // err_clr in the completion cycle beats the increment
    issue_write(32'h60, 32'h1, 4'h1, 3'b000, RESP_SLVERR, 1, acc_a);
    @(negedge clk);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("clr_priority", wr_err_cnt, 0);
    wait_idle();
    bresp_val = RESP_OKAY;
    rresp_val = RESP_OKAY;

    // Reset while AW is pending abandons the write
    aw_hold = 6;
    issue_write(32'h50, 32'h77, 4'h1, 3'b000, RESP_OKAY, 0, acc_a);
    @(negedge clk);
    @(negedge clk);
    chk("mid_awvalid", bus.awvalid, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_awvalid", bus.awvalid, 0);
    chk("rst_mid_wvalid", bus.wvalid, 0);
    chk("rst_mid_bready", bus.bready, 0);
    wr_q.delete();
    rd_q.delete();
    aw_hold = 1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_ready", wr_cmd_ready, 1);
    repeat (10) @(negedge clk);

    // Recovery after reset
    issue_write(32'h70, 32'h89ABCDEF, 4'hF, 3'b000, RESP_OKAY, 1, acc_a);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
